// File: rtl/sap_ctrl_pkg.sv
// Shared types and defaults for the SAP-1 front-panel clock controller.
// Holds the FSM state enum, the output decode struct and the timing defaults.
package sap_ctrl_pkg;

  localparam int DEF_DB_HALF   = 25000;
  localparam int DEF_RUN_HALF  = 25000000;
  localparam int DEF_STEP_HIGH = 4;

  typedef enum logic [2:0] {
    STOPPED,
    RUN_LO,
    RUN_HI,
    STEP_HI,
    HALTED
  } state_e;

  typedef struct packed {
    logic cpu_clk;
    logic running;
    logic halted;
  } ctrl_out_s;

  // Counter width able to hold 0..max-1, never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

  function automatic ctrl_out_s decode_outputs(input state_e s);
    ctrl_out_s o;
    o         = '0;
    o.cpu_clk = (s == RUN_HI) || (s == STEP_HI);
    o.running = (s == RUN_LO) || (s == RUN_HI);
    o.halted  = (s == HALTED);
    return o;
  endfunction

endpackage

// File: rtl/sap_clock_ctrl_if.sv
// Panel/CPU signal bundle around the clock controller.
// master = the controller itself, slave = panel switches plus CPU core.
interface sap_clock_ctrl_if;
  logic db_clock;
  logic run_btn;
  logic step_btn;
  logic clr_btn;
  logic halt;
  logic cpu_clk;
  logic cpu_clr;
  logic running;
  logic halted;

  modport master (
    input  run_btn, step_btn, clr_btn, halt,
    output db_clock, cpu_clk, cpu_clr, running, halted
  );

  modport slave (
    output run_btn, step_btn, clr_btn, halt,
    input  db_clock, cpu_clk, cpu_clr, running, halted
  );
endinterface

// File: rtl/sap_clock_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a single-cycle rising-edge detector.
// level is the synchronised input; rise pulses for one clock per 0->1 change.
module sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;

endmodule

// File: rtl/sap_clock_ctrl.sv
// SAP-1 front-panel clock controller: debounce prescaler plus the run/step/halt
// sequencer that is the sole source of cpu_clk and cpu_clr.
module sap_clock_ctrl
  import sap_ctrl_pkg::*;
#(
  parameter int DB_HALF   = DEF_DB_HALF,
  parameter int RUN_HALF  = DEF_RUN_HALF,
  parameter int STEP_HIGH = DEF_STEP_HIGH
) (
  input logic              clock,
  input logic              reset_n,
  sap_clock_ctrl_if.master bus
);

  localparam int DB_W   = cnt_width(DB_HALF);
  localparam int PH_MAX = (RUN_HALF > STEP_HIGH) ? RUN_HALF : STEP_HIGH;
  localparam int PH_W   = cnt_width(PH_MAX);

  logic w_run_rise;
  logic w_step_rise;
  logic w_halt;
  logic w_clr;
  logic w_unused_run_level;
  logic w_unused_step_level;
  logic w_unused_halt_rise;
  logic w_unused_clr_rise;

  sync_edge u_sync_run (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.run_btn),
    .level   (w_unused_run_level),
    .rise    (w_run_rise)
  );

  sync_edge u_sync_step (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.step_btn),
    .level   (w_unused_step_level),
    .rise    (w_step_rise)
  );

  sync_edge u_sync_halt (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.halt),
    .level   (w_halt),
    .rise    (w_unused_halt_rise)
  );

  sync_edge u_sync_clr (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.clr_btn),
    .level   (w_clr),
    .rise    (w_unused_clr_rise)
  );

  // Debounce clock prescaler: free-running in every FSM state.
  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_clock;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt   <= '0;
      r_db_clock <= 1'b0;
    end else if (r_db_cnt == DB_W'(DB_HALF - 1)) begin
      r_db_cnt   <= '0;
      r_db_clock <= ~r_db_clock;
    end else begin
      r_db_cnt   <= r_db_cnt + DB_W'(1);
    end
  end

  state_e          r_state;
  state_e          w_state_next;
  logic [PH_W-1:0] r_phase;
  logic            r_stop_pend;
  logic            w_stop_pend_next;
  logic            w_run_end;
  logic            w_step_end;
  logic            w_timed;
  ctrl_out_s       w_out;
  logic            r_cpu_clk;
  logic            r_running;
  logic            r_halted;

  assign w_run_end  = (r_phase == PH_W'(RUN_HALF - 1));
  assign w_step_end = (r_phase == PH_W'(STEP_HIGH - 1));
  assign w_timed    = r_state inside {RUN_LO, RUN_HI, STEP_HI};

  // State register; outputs are registered decodes of the next state so they
  // move on the same edge as the state without combinational glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= STOPPED;
      r_phase     <= '0;
      r_stop_pend <= 1'b0;
      r_cpu_clk   <= 1'b0;
      r_running   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stop_pend <= w_stop_pend_next;
      r_cpu_clk   <= w_out.cpu_clk;
      r_running   <= w_out.running;
      r_halted    <= w_out.halted;
      if ((w_state_next != r_state) || w_clr) begin
        r_phase <= '0;
      end else if (w_timed) begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_stop_pend_next = r_stop_pend;
    if (w_clr) begin
      w_state_next     = STOPPED;
      w_stop_pend_next = 1'b0;
    end else begin
      case (r_state)
        STOPPED: begin
          if (w_halt)           w_state_next = HALTED;
          else if (w_run_rise)  w_state_next = RUN_LO;
          else if (w_step_rise) w_state_next = STEP_HI;
        end
        RUN_LO: begin
          if (w_run_rise) begin
            w_state_next = STOPPED;
          end else if (w_run_end) begin
            if (w_halt)           w_state_next = HALTED;
            else if (r_stop_pend) w_state_next = STOPPED;
            else                  w_state_next = RUN_HI;
          end
        end
        RUN_HI: begin
          // A stop request never truncates the high phase.
          if (w_run_rise) w_stop_pend_next = 1'b1;
          if (w_run_end)  w_state_next     = RUN_LO;
        end
        STEP_HI: begin
          if (w_step_end) w_state_next = STOPPED;
        end
        HALTED:  w_state_next = HALTED;
        default: w_state_next = STOPPED;
      endcase
    end
    if ((w_state_next != RUN_LO) && (w_state_next != RUN_HI)) begin
      w_stop_pend_next = 1'b0;
    end
  end

  always_comb begin
    w_out = decode_outputs(w_state_next);
  end

  assign bus.db_clock = r_db_clock;
  assign bus.cpu_clk  = r_cpu_clk;
  assign bus.cpu_clr  = w_clr;
  assign bus.running  = r_running;
  assign bus.halted   = r_halted;

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Self-checking bench for sap_clock_ctrl: directed panel scenarios plus random
// switch activity, compared every cycle against a tick-countdown model.
module tb_sap_clock_ctrl;

  localparam int DB_HALF   = 4;
  localparam int RUN_HALF  = 5;
  localparam int STEP_HIGH = 2;

  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk_en   = 1'b0;

  sap_clock_ctrl_if bus ();

  sap_clock_ctrl #(
    .DB_HALF   (DB_HALF),
    .RUN_HALF  (RUN_HALF),
    .STEP_HIGH (STEP_HIGH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: input history (bits {clr,halt,step,run}) and a countdown
  // of remaining clocks in the current cpu_clk level.
  logic [3:0] h1, h2, h3;
  mode_t      m_mode;
  logic       m_clk;
  logic       m_stop;
  int         m_left;
  int         m_cycles;

  always @(posedge clock or negedge reset_n) begin
    logic [3:0] lvl;
    logic [3:0] rise;
    if (!reset_n) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_mode = M_IDLE; m_clk = 1'b0; m_stop = 1'b0; m_left = 0; m_cycles = 0;
    end else begin
      lvl  = h2;
      rise = h2 & ~h3;
      if (lvl[3]) begin
        m_mode = M_IDLE; m_clk = 1'b0; m_stop = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (lvl[2]) m_mode = M_HALT;
            else if (rise[0]) begin
              m_mode = M_RUN; m_clk = 1'b0; m_left = RUN_HALF; m_stop = 1'b0;
            end else if (rise[1]) begin
              m_mode = M_STEP; m_clk = 1'b1; m_left = STEP_HIGH;
            end
          end
          M_RUN: begin
            if (!m_clk) begin
              if (rise[0]) m_mode = M_IDLE;
              else begin
                m_left--;
                if (m_left == 0) begin
                  if (lvl[2])      m_mode = M_HALT;
                  else if (m_stop) m_mode = M_IDLE;
                  else begin m_clk = 1'b1; m_left = RUN_HALF; end
                end
              end
            end else begin
              if (rise[0]) m_stop = 1'b1;
              m_left--;
              if (m_left == 0) begin m_clk = 1'b0; m_left = RUN_HALF; end
            end
          end
          M_STEP: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_IDLE; m_clk = 1'b0; end
          end
          default: ;
        endcase
      end
      m_cycles++;
      h3 = h2; h2 = h1;
      h1 = {bus.clr_btn, bus.halt, bus.step_btn, bus.run_btn};
    end
  end

  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      check("outs", {27'd0, bus.db_clock, bus.cpu_clk, bus.cpu_clr, bus.running, bus.halted},
            {27'd0, 1'((m_cycles / DB_HALF) % 2), m_clk, h2[3], 1'(m_mode == M_RUN),
             1'(m_mode == M_HALT)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit r, input bit s, input bit c, input int len);
    if (r) bus.run_btn = 1'b1;
    if (s) bus.step_btn = 1'b1;
    if (c) bus.clr_btn = 1'b1;
    cyc(len);
    if (r) bus.run_btn = 1'b0;
    if (s) bus.step_btn = 1'b0;
    if (c) bus.clr_btn = 1'b0;
  endtask

  task automatic wait_cpu_clk(input logic lvl);
    int k = 0;
    while (bus.cpu_clk !== lvl && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("wait_cpu_clk", 32'(k < 60), 32'd1);
  endtask

  task automatic step_check();
    bus.step_btn = 1'b1;
    cyc(2);
    check("step_latency", 32'(bus.cpu_clk), 32'd0);
    cyc(1);
    check("step_hi0", 32'(bus.cpu_clk), 32'd1);
    cyc(1);
    check("step_hi1", 32'(bus.cpu_clk), 32'd1);
    bus.step_btn = 1'b0;
    cyc(1);
    check("step_end", 32'(bus.cpu_clk), 32'd0);
    check("step_running", 32'(bus.running), 32'd0);
    cyc(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rises;
    int cnt;
    logic prev;
    bus.run_btn = 1'b0; bus.step_btn = 1'b0; bus.clr_btn = 1'b0; bus.halt = 1'b0;
    cyc(3);
    check("rst_outs", {27'd0, bus.db_clock, bus.cpu_clk, bus.cpu_clr, bus.running, bus.halted}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // db_clock: toggles every DB_HALF clocks after reset release
    cyc(3); check("db_q0", 32'(bus.db_clock), 32'd0);
    cyc(1); check("db_q1", 32'(bus.db_clock), 32'd1);
    cyc(3); check("db_q2", 32'(bus.db_clock), 32'd1);
    cyc(1); check("db_q3", 32'(bus.db_clock), 32'd0);

    step_check();

    // Simultaneous run and step edges: run wins
    bus.run_btn = 1'b1; bus.step_btn = 1'b1;
    cyc(3);
    check("simul_running", 32'(bus.running), 32'd1);
    check("simul_no_step", 32'(bus.cpu_clk), 32'd0);
    bus.run_btn = 1'b0; bus.step_btn = 1'b0;
    cyc(2);
    check("simul_low", 32'(bus.cpu_clk), 32'd0);

    // Stop request during the high phase
    wait_cpu_clk(1'b1);
    press(1, 0, 0, 2);
    rises = 0;
    prev  = bus.cpu_clk;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.cpu_clk && !prev) rises++;
      prev = bus.cpu_clk;
    end
    check("stop_no_rise", 32'(rises), 32'd0);
    check("stop_running", 32'(bus.running), 32'd0);

    // Halt during RUN_HI, then ignored run/step edges
    press(1, 0, 0, 2);
    wait_cpu_clk(1'b1);
    bus.halt = 1'b1;
    cyc(20);
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_clk", 32'(bus.cpu_clk), 32'd0);
    press(1, 1, 0, 2);
    cyc(6);
    check("halt_ignore", {29'd0, bus.halted, bus.cpu_clk, bus.running}, 32'd4);

    // Clear out of HALTED
    bus.halt    = 1'b0;
    bus.clr_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.clr_btn = 1'b0;
      @(negedge clock);
      cnt += int'(bus.cpu_clr);
    end
    check("clr_len", 32'(cnt), 32'd3);
    check("clr_halted", 32'(bus.halted), 32'd0);
    step_check();

    // Random switch activity
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 11) == 0) bus.run_btn  = ~bus.run_btn;
      if ($urandom_range(0, 11) == 0) bus.step_btn = ~bus.step_btn;
      if ($urandom_range(0, 59) == 0) bus.halt     = ~bus.halt;
      if (bus.clr_btn) begin
        if ($urandom_range(0, 2) == 0) bus.clr_btn = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        bus.clr_btn = 1'b1;
      end
    end
    bus.run_btn = 1'b0; bus.step_btn = 1'b0; bus.halt = 1'b0;
    press(0, 0, 1, 3);
    cyc(5);
    check("rand_settle", {29'd0, bus.halted, bus.cpu_clk, bus.running}, 32'd0);

    // Asynchronous reset in the middle of a high phase
    press(1, 0, 0, 2);
    wait_cpu_clk(1'b1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("rst_mid", {27'd0, bus.db_clock, bus.cpu_clk, bus.cpu_clr, bus.running, bus.halted}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sap_clock_ctrl.md
Name: sap_clock_ctrl

Overview:
- Front-panel clock controller for the SAP-1 build. It generates the slow square-wave clock that drives the panel debounce instances and takes their debounced run/step/clear levels.
- It sequences the CPU clock through run, single-step, stop and halt, and honours the CPU HLT signal.
- It sits between the debounced switches and the CPU core. It is the only source of cpu_clk and cpu_clr.

Parameters:
- DB_HALF, 25000: system clocks per half period of db_clock (1 ms period at 50 MHz).
- RUN_HALF, 25000000: system clocks per half period of cpu_clk in run mode (1 Hz at 50 MHz). Must be ≥2.
- STEP_HIGH, 4: system clocks cpu_clk is held high for one single step. Must be ≥1.

Ports:
- clock, in, 1: fast system clock; every register in the block is clocked by it.
- reset_n, in, 1: asynchronous active-low reset.
- db_clock, out, 1: slow clock for the debounce instances; a registered square wave.
- run_btn, in, 1: debounced level; each rising edge toggles run/stop.
- step_btn, in, 1: debounced level; each rising edge requests one CPU clock pulse.
- clr_btn, in, 1: debounced level; CPU clear request.
- halt, in, 1: CPU HLT output.
- cpu_clk, out, 1: CPU clock; registered, glitch-free.
- cpu_clr, out, 1: CPU clear, active high.
- running, out, 1: high in RUN_LO and RUN_HI.
- halted, out, 1: high in HALTED.

Behaviour:
- Reset values:
  - db_clock=0, cpu_clk=0, cpu_clr=0, running=0, halted=0.
  - State STOPPED; all counters 0; stop_pending=0; synchroniser and edge-history flops 0.
- db prescaler:
  - Counter 0..DB_HALF-1; db_clock toggles on wrap. It free-runs in every state.
- Input conditioning:
  - run_btn, step_btn, clr_btn and halt each pass through a 2-flop synchroniser.
  - Rising edge = synchronised value 1 and previous synchronised value 0. Edges are single-cycle.
  - Latency from input change to FSM action is 3 clocks.
- FSM states: STOPPED, RUN_LO, RUN_HI, STEP_HI, HALTED. The phase counter resets to 0 on every state entry.
  - STOPPED, cpu_clk=0:
    - halt_s=1 → HALTED.
    - Else run edge → RUN_LO.
    - Else step edge → STEP_HI.
  - RUN_LO, cpu_clk=0: on count RUN_HALF-1, in priority order:
    - halt_s=1 → HALTED.
    - stop_pending → STOPPED, clear stop_pending.
    - Otherwise → RUN_HI.
  - RUN_HI, cpu_clk=1: on count RUN_HALF-1 → RUN_LO.
  - STEP_HI, cpu_clk=1: on count STEP_HIGH-1 → STOPPED.
  - HALTED, cpu_clk=0: left only via clear.
- Run-edge handling:
  - In RUN_LO, a run edge goes straight to STOPPED.
  - In RUN_HI, a run edge sets stop_pending. The high phase is never truncated; after the full low phase the FSM enters STOPPED.
- Ignored edges:
  - Step edges are ignored outside STOPPED.
  - Run edges are ignored in STEP_HI and HALTED.
- Simultaneous run and step edges in STOPPED: run wins, step is discarded.
- Clear: while clr_s=1, cpu_clr=1 and the FSM is forced to STOPPED in the same cycle, regardless of state.
  - This clears stop_pending and the phase counter, and forces cpu_clk low on the next edge.
  - Edges arriving during clear are discarded.
  - The FSM resumes normal operation on the first cycle with clr_s=0.
- Outputs cpu_clk, running and halted are registered decodes of the next state. They change on the same edge as the state, with no combinational glitches.
- Counter widths are $clog2 of their max; compares use full width; no wrap beyond max.
- Asynchronous reset mid-operation returns immediately to the reset values, including mid high phase.

Decomposition:
- Shared package sap_ctrl_pkg holds:
  - the state enum (STOPPED, RUN_LO, RUN_HI, STEP_HI, HALTED);
  - default values for DB_HALF, RUN_HALF and STEP_HIGH.
- Sub-module sync_edge: 2-flop synchroniser plus rising-edge detector, one instance per input. Ports: clock, reset_n, d, level, rise.
- Prescaler and FSM live in sap_clock_ctrl itself.

Test Plan:
(All scenarios use DB_HALF=4, RUN_HALF=5, STEP_HIGH=2.)
- Reset:
  - Stimulus: hold reset_n=0, then release.
  - Required: all outputs 0; db_clock toggles every 4 clocks, period 8.
- Single step:
  - Stimulus: step_btn rises.
  - Required: cpu_clk high exactly 2 clocks, starting 3 clocks after the input; back to STOPPED; running=0.
- Run then stop:
  - Stimulus: run edge, then a second run edge issued during RUN_HI.
  - Required: cpu_clk alternates 5 low / 5 high. After the second edge the high phase completes, then 5 low, then STOPPED with no further rising edge.
- Halt:
  - Stimulus: running, halt asserted during RUN_HI.
  - Required: the current high finishes, 5 low, then HALTED; halted=1; cpu_clk stays 0; step and run edges ignored.
- Clear:
  - Stimulus: from HALTED, clr_btn pulsed for 3 clocks.
  - Required: cpu_clr=1 for 3 clocks (delayed 2), halted→0, state STOPPED. A subsequent step edge produces one pulse (halt low).
- Simultaneous edges:
  - Stimulus: run_btn and step_btn rise on the same clock in STOPPED.
  - Required: enter RUN_LO; no STEP_HI pulse.
